wb_data_cache_controller: RTL and testbench

WB_DATA_CACHE_CONTROLLER -- requirements
Module: wb_data_cache_controller

---
 rtl/dcache_pkg.sv | 4 +
 rtl/wb_data_cache_controller_if.sv | 14 +
 rtl/dcache_word_counter.sv | 13 +
 rtl/wb_data_cache_controller.sv | 39 +++
 tb/tb_wb_data_cache_controller.sv | 95 +++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: cache-controller state encoding shared with the instruction-cache controller.
package dcache_pkg;
   typedef enum logic [1:0] {READY, WRITEBACK, FILL} state_t;
endpackage

// File: rtl/wb_data_cache_controller_if.sv
// wb_data_cache_controller_if: CPU/cache/memory control signals of the data-cache controller.
interface wb_data_cache_controller_if #(parameter int WOB = 2);
   logic re, we, hit, dirty, busready;
   logic stall, memread, memwrite, cwe, cachesrc, setdirty, setvalid, wbaddr;
   logic [WOB-1:0] wordcount;
   modport master (
      output re, we, hit, dirty, busready,
      input  stall, memread, memwrite, cwe, cachesrc, setdirty, setvalid, wbaddr, wordcount
   );
   modport slave (
      input  re, we, hit, dirty, busready,
      output stall, memread, memwrite, cwe, cachesrc, setdirty, setvalid, wbaddr, wordcount
   );
endinterface

// File: rtl/dcache_word_counter.sv
// dcache_word_counter: word offset of the current line transfer; wraps naturally after the last word.
module dcache_word_counter #(parameter int WOB = 2) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           inc,
   output logic [WOB-1:0] count,
   output logic           last
);
   always_ff @(posedge clk)
      count <= (reset | clear) ? '0 : inc ? count + 1'b1 : count;
   assign last = &count;
endmodule

// File: rtl/wb_data_cache_controller.sv
// wb_data_cache_controller: write-back, write-allocate data-cache control FSM.
module wb_data_cache_controller
   import dcache_pkg::*;
#(parameter int BLOCKWORDS = 4) (
   input logic clk,
   input logic reset,
   wb_data_cache_controller_if.slave bus
);
   localparam int WOB = $clog2(BLOCKWORDS);
   state_t state;
   logic rdy, fill, last, req, miss, st_hit, done;
   assign rdy    = state == READY;
   assign fill   = state == FILL;
   assign req    = bus.re | bus.we;
   assign miss   = rdy & req & ~bus.hit;
   assign st_hit = rdy & bus.we & bus.hit;
   assign done   = fill & bus.busready & last;
   // Holding the counter clear in READY guarantees offset 0 on every transfer entry.
   dcache_word_counter #(.WOB(WOB)) u_cnt (
      .clk(clk),
      .reset(reset),
      .clear(rdy),
      .inc(~rdy & bus.busready),
      .count(bus.wordcount),
      .last(last)
   );
   always_ff @(posedge clk)
      state <= reset ? READY :
               rdy ? (miss ? (bus.dirty ? WRITEBACK : FILL) : READY) :
               (bus.busready & last) ? (fill ? READY : FILL) : state;
   assign bus.stall    = ~rdy | miss;
   assign bus.memwrite = state == WRITEBACK;
   assign bus.wbaddr   = state == WRITEBACK;
   assign bus.memread  = fill;
   assign bus.cachesrc = fill;
   assign bus.cwe      = fill ? bus.busready : st_hit;
   assign bus.setdirty = st_hit | done;
   assign bus.setvalid = done;
endmodule

// File: tb/tb_wb_data_cache_controller.sv
// tb_wb_data_cache_controller: directed vectors checked through an expectation queue.
module tb_wb_data_cache_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_data_cache_controller_if #(.WOB(2)) bus ();
   wb_data_cache_controller #(.BLOCKWORDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      string      name;
      logic [9:0] exp;
   } exp_t;
   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // {stall,memread,memwrite,cwe,cachesrc,setdirty,setvalid,wbaddr,wordcount}
   function automatic logic [9:0] outs();
      return {bus.stall, bus.memread, bus.memwrite, bus.cwe, bus.cachesrc,
              bus.setdirty, bus.setvalid, bus.wbaddr, bus.wordcount};
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (outs() !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", e.name, outs(), e.exp);
         end
      end
   end

   // in = {re,we,hit,dirty,busready}
   task automatic step(input string name, input logic r, input logic [4:0] in,
                       input logic chk, input logic [9:0] exp);
      @(posedge clk);
      #1;
      reset = r;
      {bus.re, bus.we, bus.hit, bus.dirty, bus.busready} = in;
      if (chk) q.push_back('{name, exp});
   endtask

   localparam logic [9:0] IDLE  = 10'b0_0_0_0_0_0_0_0_00;
   localparam logic [9:0] STH   = 10'b0_0_0_1_0_1_0_0_00;
   localparam logic [9:0] MISS  = 10'b1_0_0_0_0_0_0_0_00;

   initial begin
      {bus.re, bus.we, bus.hit, bus.dirty, bus.busready} = 5'b0;
      step("rst0", 1'b1, 5'b00000, 1'b0, IDLE);
      step("rst1", 1'b1, 5'b00000, 1'b0, IDLE);
      step("idle",     1'b0, 5'b00000, 1'b1, IDLE);
      step("idle_ign", 1'b0, 5'b00111, 1'b1, IDLE);
      step("ld_hit",   1'b0, 5'b10100, 1'b1, IDLE);
      step("st_hit",   1'b0, 5'b01100, 1'b1, STH);
      step("rw_hit",   1'b0, 5'b11100, 1'b1, STH);
      step("ld_miss",  1'b0, 5'b10001, 1'b1, MISS);
      step("fill0",    1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_00);
      step("fill1",    1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_01);
      step("fill2",    1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_10);
      step("fill3",    1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_1_1_0_11);
      step("st_miss",  1'b0, 5'b01010, 1'b1, MISS);
      step("wb0",      1'b0, 5'b01011, 1'b1, 10'b1_0_1_0_0_0_0_1_00);
      step("wb1_hold", 1'b0, 5'b01010, 1'b1, 10'b1_0_1_0_0_0_0_1_01);
      step("wb1",      1'b0, 5'b01011, 1'b1, 10'b1_0_1_0_0_0_0_1_01);
      step("wb2_hold", 1'b0, 5'b01010, 1'b1, 10'b1_0_1_0_0_0_0_1_10);
      step("wb2",      1'b0, 5'b01011, 1'b1, 10'b1_0_1_0_0_0_0_1_10);
      step("wb3_hold", 1'b0, 5'b01010, 1'b1, 10'b1_0_1_0_0_0_0_1_11);
      step("wb3",      1'b0, 5'b01011, 1'b1, 10'b1_0_1_0_0_0_0_1_11);
      step("wfill0",   1'b0, 5'b01011, 1'b1, 10'b1_1_0_1_1_0_0_0_00);
      step("wfill1",   1'b0, 5'b01011, 1'b1, 10'b1_1_0_1_1_0_0_0_01);
      step("wfill2",   1'b0, 5'b01011, 1'b1, 10'b1_1_0_1_1_0_0_0_10);
      step("wfill3",   1'b0, 5'b01011, 1'b1, 10'b1_1_0_1_1_1_1_0_11);
      step("st_replay",1'b0, 5'b01100, 1'b1, STH);
      step("ld_miss2", 1'b0, 5'b10001, 1'b1, MISS);
      step("rf0",      1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_00);
      step("rf1",      1'b0, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_01);
      step("rf2_hold", 1'b0, 5'b10000, 1'b1, 10'b1_1_0_0_1_0_0_0_10);
      step("rf2_rst",  1'b1, 5'b10001, 1'b1, 10'b1_1_0_1_1_0_0_0_10);
      step("post_rst", 1'b0, 5'b00000, 1'b1, IDLE);
      step("post_miss",1'b0, 5'b10000, 1'b1, MISS);
      step("tail",     1'b1, 5'b00000, 1'b0, IDLE);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
